// File: rtl/ps2_cmd_pkg.sv
// Shared constants, FSM state type and scan-code lookup tables for the PS/2 command decoder.
// Pure declarations: no timing or flow-control behaviour lives here.
package ps2_cmd_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [3:0] CMD_KEY1  = 4'h0;
  localparam logic [3:0] CMD_KEY2  = 4'h1;
  localparam logic [3:0] CMD_KEY3  = 4'h2;
  localparam logic [3:0] CMD_KEY4  = 4'h3;
  localparam logic [3:0] CMD_RED   = 4'h4;
  localparam logic [3:0] CMD_GREEN = 4'h5;
  localparam logic [3:0] CMD_BLUE  = 4'h6;
  localparam logic [3:0] CMD_UP    = 4'h7;
  localparam logic [3:0] CMD_DOWN  = 4'h8;
  localparam logic [3:0] CMD_LEFT  = 4'h9;
  localparam logic [3:0] CMD_RIGHT = 4'hA;
  localparam logic [3:0] CMD_PLUS  = 4'hB;
  localparam logic [3:0] CMD_MINUS = 4'hC;
  localparam logic [3:0] CMD_KP4   = 4'hD;
  localparam logic [3:0] CMD_NONE  = 4'hF;

  // The Pause key sends E1 followed by seven more bytes that carry no key meaning.
  localparam logic [2:0] PAUSE_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } map_t;

  function automatic map_t plain_map(input logic [7:0] b);
    map_t m;
    m.hit  = 1'b1;
    m.code = CMD_NONE;
    case (b)
      8'h16:   m.code = CMD_KEY1;
      8'h1E:   m.code = CMD_KEY2;
      8'h26:   m.code = CMD_KEY3;
      8'h25:   m.code = CMD_KEY4;
      8'h2D:   m.code = CMD_RED;
      8'h34:   m.code = CMD_GREEN;
      8'h32:   m.code = CMD_BLUE;
      8'h79:   m.code = CMD_PLUS;
      8'h7B:   m.code = CMD_MINUS;
      8'h6B:   m.code = CMD_KP4;
      default: m.hit  = 1'b0;
    endcase
    return m;
  endfunction

  function automatic map_t ext_map(input logic [7:0] b);
    map_t m;
    m.hit  = 1'b1;
    m.code = CMD_NONE;
    case (b)
      8'h75:   m.code = CMD_UP;
      8'h72:   m.code = CMD_DOWN;
      8'h6B:   m.code = CMD_LEFT;
      8'h74:   m.code = CMD_RIGHT;
      default: m.hit  = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_cmd_fifo.sv
// First-word-fall-through queue: a push is visible at head one cycle later.
// When full, a push is taken only alongside a pop; otherwise it is refused.
module ps2_cmd_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code to command decoder; a final byte appears at cmdValid one cycle later.
// Events are queued via valid/ready; a full queue without a pop drops the event and sets overflow.
module ps2_cmd_decoder
  import ps2_cmd_pkg::*;
#(
  parameter int CMD_W         = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_FILTER = 1,
  parameter int EMIT_RELEASE  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          scanValid,
  input  logic [7:0]                    scanCode,
  input  logic                          cmdReady,
  output logic                          cmdValid,
  output logic [CMD_W-1:0]              cmdCode,
  output logic                          cmdRelease,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic                          overflow
);
  localparam logic [CMD_W-1:0] CODE_NONE = '1;

  state_t           state, state_nx;
  logic [2:0]       pause_cnt, pause_cnt_nx;
  logic [CMD_W-1:0] held, held_nx;
  logic             ev_vld, ev_rel;
  logic [CMD_W-1:0] ev_code;
  map_t             pm, xm;
  logic             push, pop, full, empty;
  logic [CMD_W:0]   push_dat, head;

  assign pm = plain_map(scanCode);
  assign xm = ext_map(scanCode);

  always_comb begin
    state_nx     = state;
    pause_cnt_nx = pause_cnt;
    ev_vld       = 1'b0;
    ev_rel       = 1'b0;
    ev_code      = CODE_NONE;
    if (scanValid) begin
      unique case (state)
        ST_IDLE: begin
          if (scanCode == PS2_EXT) state_nx = ST_EXT;
          else if (scanCode == PS2_BRK) state_nx = ST_BRK;
          else if (scanCode == PS2_PAUSE) begin
            state_nx     = ST_PAUSE;
            pause_cnt_nx = PAUSE_LEN;
          end else begin
            ev_vld  = pm.hit;
            ev_code = CMD_W'(pm.code);
          end
        end
        ST_EXT: begin
          if (scanCode == PS2_BRK) state_nx = ST_EXT_BRK;
          else if (scanCode == PS2_EXT) state_nx = ST_EXT;
          else begin
            ev_vld   = xm.hit;
            ev_code  = CMD_W'(xm.code);
            state_nx = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (scanCode != PS2_BRK) begin
            ev_vld   = pm.hit;
            ev_rel   = 1'b1;
            ev_code  = CMD_W'(pm.code);
            state_nx = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          ev_vld   = xm.hit;
          ev_rel   = 1'b1;
          ev_code  = CMD_W'(xm.code);
          state_nx = ST_IDLE;
        end
        ST_PAUSE: begin
          pause_cnt_nx = pause_cnt - 1'b1;
          if (pause_cnt <= 3'd1) state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // held tracks the key currently down so typematic repeats can be filtered.
  always_comb begin
    held_nx  = held;
    push     = 1'b0;
    push_dat = {ev_rel, ev_code};
    if (ev_vld) begin
      if (!ev_rel) begin
        if (!((REPEAT_FILTER != 0) && (ev_code == held))) begin
          held_nx = ev_code;
          push    = 1'b1;
        end
      end else begin
        if (ev_code == held) held_nx = CODE_NONE;
        push = (EMIT_RELEASE != 0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pause_cnt <= '0;
      held      <= CODE_NONE;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      pause_cnt <= pause_cnt_nx;
      held      <= held_nx;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign pop = ~empty & cmdReady;

  ps2_cmd_fifo #(
    .WIDTH (CMD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .level    (fifoLevel),
    .full     (full),
    .empty    (empty)
  );

  assign cmdValid   = ~empty;
  assign cmdCode    = empty ? CODE_NONE : head[CMD_W-1:0];
  assign cmdRelease = ~empty & head[CMD_W];

endmodule
